// File: rtl/vga_pkg.sv
// Shared 800x600 @ 60 Hz raster constants, coordinate type and small decode helpers
// for the VGA timing generator.
package vga_pkg;

  localparam int COORD_W   = 12;
  localparam int COORD_MAX = (1 << COORD_W) - 1;

  localparam int VGA_H_ACTIVE = 800;
  localparam int VGA_H_FP     = 40;
  localparam int VGA_H_SYNC   = 128;
  localparam int VGA_H_BP     = 88;
  localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  localparam int VGA_V_ACTIVE = 600;
  localparam int VGA_V_FP     = 1;
  localparam int VGA_V_SYNC   = 4;
  localparam int VGA_V_BP     = 23;
  localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  typedef logic [COORD_W-1:0] coord_t;

  typedef struct packed {
    logic hsync;
    logic hblnk;
    logic vsync;
    logic vblnk;
  } sync_flags_t;

  function automatic logic in_range(coord_t val, coord_t lo, coord_t hi);
    return (val >= lo) && (val <= hi);
  endfunction

endpackage

// File: rtl/vga_timing_wrap_counter.sv
// Up-counter that returns to zero after reaching a programmable wrap value; the
// wrap flag is combinational so a following counter can chain off it.
module wrap_counter #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] wrap_val,
  output logic [W-1:0] count,
  output logic         wrap
);

  assign wrap = en && (count == wrap_val);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (wrap) begin
      count <= '0;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/vga_timing.sv
// Free-running raster timing generator: pixel/line counters plus sync and blanking
// flags, all registered in one stage so every flag matches the coordinates beside it.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP
) (
  input  logic               pclk,
  input  logic               rst,
  output logic [COORD_W-1:0] hcount,
  output logic               hsync,
  output logic               hblnk,
  output logic [COORD_W-1:0] vcount,
  output logic               vsync,
  output logic               vblnk
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam coord_t H_MAX      = coord_t'(H_TOTAL - 1);
  localparam coord_t H_BLK_FIRST = coord_t'(H_ACTIVE);
  localparam coord_t HS_FIRST   = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t HS_LAST    = coord_t'(H_ACTIVE + H_FP + H_SYNC - 1);

  localparam coord_t V_MAX      = coord_t'(V_TOTAL - 1);
  localparam coord_t V_BLK_FIRST = coord_t'(V_ACTIVE);
  localparam coord_t VS_FIRST   = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t VS_LAST    = coord_t'(V_ACTIVE + V_FP + V_SYNC - 1);

  if (H_TOTAL > COORD_MAX || V_TOTAL > COORD_MAX ||
      H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_params
    $error("vga_timing: totals must fit 12 bits and porch/sync widths must be non-zero");
  end

  coord_t      h_cnt, v_cnt;
  logic        h_wrap, v_wrap;
  coord_t      h_next_p0, v_next_p0;
  sync_flags_t flags_p1;

  wrap_counter #(.W(COORD_W)) u_hcnt (
    .clk      (pclk),
    .rst      (rst),
    .en       (1'b1),
    .wrap_val (H_MAX),
    .count    (h_cnt),
    .wrap     (h_wrap)
  );

  wrap_counter #(.W(COORD_W)) u_vcnt (
    .clk      (pclk),
    .rst      (rst),
    .en       (h_wrap),
    .wrap_val (V_MAX),
    .count    (v_cnt),
    .wrap     (v_wrap)
  );

  // p0: coordinates the counters will hold after this edge
  always_comb begin
    h_next_p0 = h_wrap ? '0 : h_cnt + coord_t'(1);
    v_next_p0 = v_cnt;
    if (v_wrap) begin
      v_next_p0 = '0;
    end else if (h_wrap) begin
      v_next_p0 = v_cnt + coord_t'(1);
    end
  end

  // p1: flags registered on the same edge as the counters they describe
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      flags_p1 <= '0;
    end else begin
      flags_p1.hblnk <= in_range(h_next_p0, H_BLK_FIRST, H_MAX);
      flags_p1.hsync <= in_range(h_next_p0, HS_FIRST, HS_LAST);
      flags_p1.vblnk <= in_range(v_next_p0, V_BLK_FIRST, V_MAX);
      flags_p1.vsync <= in_range(v_next_p0, VS_FIRST, VS_LAST);
    end
  end

  assign hcount = h_cnt;
  assign vcount = v_cnt;
  assign hsync  = flags_p1.hsync;
  assign hblnk  = flags_p1.hblnk;
  assign vsync  = flags_p1.vsync;
  assign vblnk  = flags_p1.vblnk;

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: a full-size instance for the 800-pixel line profile and a
// reduced-geometry instance (28 x 12) for frame-level behaviour and a scoreboard.
module tb_vga_timing;

  typedef struct packed {
    logic [11:0] h;
    logic [11:0] v;
    logic        hs;
    logic        hb;
    logic        vs;
    logic        vb;
  } exp_t;

  logic pclk = 1'b0;
  logic rst_d, rst_s;

  logic [11:0] hcount_d, vcount_d, hcount_s, vcount_s;
  logic        hsync_d, hblnk_d, vsync_d, vblnk_d;
  logic        hsync_s, hblnk_s, vsync_s, vblnk_s;

  int tests = 0;
  int fails = 0;

  exp_t q_s[$];

  always #5 pclk = ~pclk;

  vga_timing dut_d (
    .pclk   (pclk),
    .rst    (rst_d),
    .hcount (hcount_d),
    .hsync  (hsync_d),
    .hblnk  (hblnk_d),
    .vcount (vcount_d),
    .vsync  (vsync_d),
    .vblnk  (vblnk_d)
  );

  // Small geometry: line 16+3+5+4 = 28, frame 6+1+2+3 = 12 lines.
  vga_timing #(
    .H_ACTIVE(16), .H_FP(3), .H_SYNC(5), .H_BP(4),
    .V_ACTIVE(6),  .V_FP(1), .V_SYNC(2), .V_BP(3)
  ) dut_s (
    .pclk   (pclk),
    .rst    (rst_s),
    .hcount (hcount_s),
    .hsync  (hsync_s),
    .hblnk  (hblnk_s),
    .vcount (vcount_s),
    .vsync  (vsync_s),
    .vblnk  (vblnk_s)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Hand-derived boundaries of the small geometry: hblnk 16..27, hsync 19..23,
  // vblnk 6..11, vsync 7..8.
  function automatic exp_t pix_s(int h, int v);
    exp_t e;
    e.h  = 12'(h);
    e.v  = 12'(v);
    e.hb = (h >= 16);
    e.hs = (h >= 19) && (h <= 23);
    e.vb = (v >= 6);
    e.vs = (v == 7) || (v == 8);
    return e;
  endfunction

  always @(negedge pclk) begin : monitor_s
    exp_t e;
    if (q_s.size() > 0) begin
      e = q_s.pop_front();
      chk("sb_pix{h,v,hs,hb,vs,vb}",
          {hcount_s, vcount_s, hsync_s, hblnk_s, vsync_s, vblnk_s}, e);
    end
  end

  // Frame-level profile on the small instance between the first two vsync rises.
  int   cyc = 0, rises = 0, last_rise = 0, vs_cnt = 0, vb_cnt = 0;
  logic prev_vs_s = 1'b0;
  always @(negedge pclk) begin : frame_obs
    cyc++;
    if (vsync_s && !prev_vs_s) begin
      if (rises == 1) begin
        chk("frame_period", cyc - last_rise, 336);
        chk("vsync_cycles", vs_cnt, 56);
        chk("vblnk_cycles", vb_cnt, 168);
      end
      rises++;
      last_rise = cyc;
      vs_cnt = 0;
      vb_cnt = 0;
    end
    if (vsync_s) vs_cnt++;
    if (vblnk_s) vb_cnt++;
    prev_vs_s = vsync_s;
  end

  // One-register downstream consumer: blanking must match the visible area exactly.
  logic [11:0] c_h, c_v;
  logic        c_blank;
  logic        c_vld = 1'b0;
  always @(posedge pclk) begin
    c_h     <= hcount_s;
    c_v     <= vcount_s;
    c_blank <= hblnk_s | vblnk_s;
    c_vld   <= 1'b1;
  end
  always @(negedge pclk) begin
    if (c_vld) chk("align_blank", c_blank, !((c_h < 16) && (c_v < 6)));
  end

  task automatic small_seq();
    int  mh, mv, guard;
    bit  mid_done;
    mh = 0; mv = 0; mid_done = 0; guard = 0;
    rst_s = 1'b1;
    repeat (3) begin
      @(posedge pclk);
      q_s.push_back(pix_s(0, 0));
    end
    #3 rst_s = 1'b0;
    while (!mid_done && guard < 2000) begin
      @(posedge pclk);
      guard++;
      mh++;
      if (mh == 28) begin
        mh = 0;
        mv++;
        if (mv == 12) mv = 0;
      end
      if (guard > 700 && mh == 10 && mv == 5) begin
        q_s.push_back(pix_s(0, 0));
        #1;
        chk("mid_pre_h", hcount_s, 10);
        chk("mid_pre_v", vcount_s, 5);
        #1 rst_s = 1'b1;
        #1;
        chk("mid_rst_h", hcount_s, 0);
        chk("mid_rst_v", vcount_s, 0);
        chk("mid_rst_flags", {hsync_s, hblnk_s, vsync_s, vblnk_s}, 0);
        mid_done = 1;
      end else begin
        q_s.push_back(pix_s(mh, mv));
      end
    end
    chk("mid_reached", mid_done, 1);
    repeat (2) begin
      @(posedge pclk);
      q_s.push_back(pix_s(0, 0));
    end
    #3 rst_s = 1'b0;
    mh = 0; mv = 0;
    repeat (60) begin
      @(posedge pclk);
      mh++;
      if (mh == 28) begin
        mh = 0;
        mv++;
      end
      q_s.push_back(pix_s(mh, mv));
    end
  endtask

  task automatic dflt_seq();
    int   hs_n, hb_n, vf_n, hs_rise, hs_fall, last_h;
    logic prev_hs;
    rst_d = 1'b1;
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    chk("d_rst_h", hcount_d, 0);
    chk("d_rst_v", vcount_d, 0);
    chk("d_rst_flags", {hsync_d, hblnk_d, vsync_d, vblnk_d}, 0);
    #2 rst_d = 1'b0;
    @(posedge pclk);
    #1;
    chk("d_first_h", hcount_d, 1);
    chk("d_first_v", vcount_d, 0);
    hs_n = 0; hb_n = 0; vf_n = 0; hs_rise = -1; hs_fall = -1; last_h = -1;
    prev_hs = 1'b0;
    repeat (1055) begin
      @(negedge pclk);
      if (hsync_d) hs_n++;
      if (hblnk_d) hb_n++;
      if (vsync_d || vblnk_d) vf_n++;
      if (hsync_d && !prev_hs) hs_rise = hcount_d;
      if (!hsync_d && prev_hs) hs_fall = hcount_d;
      prev_hs = hsync_d;
      last_h = hcount_d;
    end
    chk("d_line_end_h", last_h, 1055);
    chk("d_line_end_v", vcount_d, 0);
    chk("d_hsync_cycles", hs_n, 128);
    chk("d_hblnk_cycles", hb_n, 256);
    chk("d_hsync_rise_at", hs_rise, 840);
    chk("d_hsync_fall_at", hs_fall, 968);
    chk("d_vflags_line0", vf_n, 0);
    @(negedge pclk);
    chk("d_wrap_h", hcount_d, 0);
    chk("d_wrap_v", vcount_d, 1);
    chk("d_wrap_hblnk", hblnk_d, 0);
    repeat (1056) @(negedge pclk);
    chk("d_line2_h", hcount_d, 0);
    chk("d_line2_v", vcount_d, 2);
  endtask

  initial begin : watchdog
    #100000;
    tests++;
    fails++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : main
    rst_d = 1'b1;
    rst_s = 1'b1;
    fork
      small_seq();
      dflt_seq();
    join
    repeat (3) @(negedge pclk);
    chk("sb_drained", q_s.size(), 0);
    chk("vsync_rises_seen", rises >= 2, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vga_timing.md
# vga_timing

Free-running 800x600 @ 60 Hz (40 MHz pixel clock) raster timing generator. It produces the horizontal and vertical pixel counters, sync pulses and blanking flags that feed the background-drawing stage directly downstream. All outputs are registered and mutually aligned: every flag describes the pixel whose coordinates appear on the counters in the same cycle.

## Interface

Parameters:
- H_ACTIVE, 800, visible pixels per line
- H_FP, 40, horizontal front porch (pixels)
- H_SYNC, 128, horizontal sync width (pixels)
- H_BP, 88, horizontal back porch (pixels); line total = 1056
- V_ACTIVE, 600, visible lines per frame
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 4, vertical sync width (lines)
- V_BP, 23, vertical back porch (lines); frame total = 628

Ports:
- pclk  in  1  pixel clock, 40 MHz
- rst  in  1  reset; one clock, asynchronous, active-high
- hcount  out  12  horizontal pixel index, 0..1055
- hsync  out  1  horizontal sync, active-high
- hblnk  out  1  horizontal blanking
- vcount  out  12  line index, 0..627
- vsync  out  1  vertical sync, active-high
- vblnk  out  1  vertical blanking

## Operation

- H counter: increments by 1 each pclk. Wraps 1055 -> 0.
- V counter: increments only on the H wrap cycle. Wraps 627 -> 0 on the cycle where both counters are at their maximum.
- hblnk = 1 for hcount >= 800.
- hsync = 1 for 840 <= hcount <= 967.
- vblnk = 1 for vcount >= 600.
- vsync = 1 for 601 <= vcount <= 604.
- vsync/vblnk change only on the H wrap edge. They are never asserted mid-line.
- Flags are decoded from the next-state counter values and registered together with the counters. No output depends combinationally on another output.
- Width rule: counters are 12 bits. Elaboration must fail (assertion) if the line total or frame total exceeds 4095, or if any porch or sync parameter is 0.
- No enable input. The generator runs continuously after reset.

## Timing

- Reset (async assert): hcount = 0, vcount = 0, hsync = 0, hblnk = 0, vsync = 0, vblnk = 0. These are the correct flags for pixel (0,0).
- First rising edge after rst deasserts: hcount = 1, vcount = 0.
- Latency: zero between a count value and its flags; they are in the same register stage.
- Line period: exactly 1056 cycles. Frame period: exactly 663,168 cycles.
- hsync rises on the edge producing hcount = 840 and falls on the edge producing hcount = 968.
- Frame wrap: on the edge after (1055, 627), outputs become (0, 0) with vblnk = 0. vblnk falls in that same cycle.
- Reset mid-frame: all outputs return to reset values immediately, without waiting for a clock. Counting restarts from (0,0) after deassertion.
- Downstream consumer adds exactly one register stage. The rgb it produces is aligned to the counters delayed by one cycle.

## Structure

- Shared package vga_pkg holds the 800x600 timing constants (active, porch, sync, totals) and the 12-bit coordinate width. The parameters default from these constants.
- One natural sub-module: wrap_counter, a parameterised counter.
  - Inputs: clock, async reset, count enable, wrap value.
  - Outputs: registered count and a combinational wrap flag, asserted when enabled and at the wrap value.
  - Instantiated twice: H always enabled; V enabled by the H wrap flag.
- Decode logic and the output register stage live in vga_timing itself.

## Test plan

- Reset: hold rst while clocking, then release at an arbitrary phase. Outputs stay all-zero during reset; hcount = 1 on the first edge after release.
- Horizontal profile: over one line, hblnk is high for exactly 256 cycles starting at hcount 800. hsync is high for exactly 128 cycles, hcount 840..967. hcount steps 1055 -> 0 while vcount increments.
- Vertical profile: over one full frame, vblnk is high for 28 lines starting at vcount 600. vsync is high for lines 601..604, i.e. 4 × 1056 = 4224 cycles. vcount steps 627 -> 0 after hcount 1055.
- Frame period: measure the cycles between consecutive vsync rising edges. The result is exactly 663,168.
- Async reset mid-frame: assert rst between clock edges at vcount = 300, hcount = 500. All outputs go to 0 before the next pclk edge. After release the sequence restarts identically to the first reset.
- Alignment: a one-register consumer model checks that every pixel with vcount < 600 and hcount < 800 has hblnk = vblnk = 0, and every other pixel has at least one blanking flag set, across two frames.
